// File: rtl/load_align_unit.sv
// Load alignment unit: fetches one or two bus words for a byte/half/word/dword load,
// then shifts, truncates and sign/zero-extends the addressed bytes (little-endian).
module load_align_unit #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  output logic              mem_rd_valid,
  input  logic              mem_rd_ready,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFS_W = $clog2(BYTES);
  localparam logic [OFS_W+1:0]  BYTES_L = (OFS_W+2)'(BYTES);
  localparam logic [ADDR_W-1:0] BYTES_A = ADDR_W'(BYTES);

  typedef enum logic [2:0] {IDLE, RD0, WAIT0, RD1, WAIT1, RESP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   beat0_q, beat0_d;
  logic [DATA_W-1:0]   beat1_q, beat1_d;

  // Size 3 wraps to 0 when DATA_W=32; that case always takes the error path.
  function automatic logic [OFS_W:0] nbytes(input logic [1:0] size);
    return (OFS_W+1)'(1) << size;
  endfunction

  function automatic logic [ADDR_W-1:0] base_of(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
  endfunction

  function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr, input logic [1:0] size);
    return (addr[OFS_W-1:0] & OFS_W'(nbytes(size) - 1'b1)) != '0;
  endfunction

  function automatic logic is_crossing(input logic [ADDR_W-1:0] addr, input logic [1:0] size);
    return ((OFS_W+2)'(addr[OFS_W-1:0]) + (OFS_W+2)'(nbytes(size))) > BYTES_L;
  endfunction

  function automatic logic [DATA_W-1:0] align(input logic [2*DATA_W-1:0] beats,
                                              input logic [OFS_W-1:0] ofs,
                                              input logic [1:0] size, input logic sgn);
    int                sh_amt;
    int                nbits;
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] mask;
    logic              sbit;
    sh_amt = 8 * int'(ofs);
    nbits  = 8 << size;
    lo     = DATA_W'(beats >> sh_amt);
    mask   = ~({DATA_W{1'b1}} << nbits);
    sbit   = sgn & 1'(beats >> (sh_amt + nbits - 1));
    return (lo & mask) | (sbit ? ~mask : '0);
  endfunction

  always_comb begin
    // NOTE: every _d starts as its _q, so no branch can leave a latch behind.
    state_d   = state_q;
    addr_d    = addr_q;
    rd_addr_d = rd_addr_q;
    size_d    = size_q;
    signed_d  = signed_q;
    err_d     = err_q;
    beat0_d   = beat0_q;
    beat1_d   = beat1_q;
    unique case (state_q)
      IDLE: if (req_valid) begin
        addr_d   = req_addr;
        size_d   = req_size;
        signed_d = req_signed;
        beat0_d  = '0;
        beat1_d  = '0;
        if ((req_size == 2'd3 && DATA_W != 64) ||
            (!SPLIT_EN && is_misaligned(req_addr, req_size))) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          err_d     = 1'b0;
          rd_addr_d = base_of(req_addr);
          state_d   = RD0;
        end
      end
      RD0:   if (mem_rd_ready) state_d = WAIT0;
      WAIT0: if (mem_rsp_valid) begin
        beat0_d = mem_rsp_data;
        if (is_crossing(addr_q, size_q)) begin
          rd_addr_d = base_of(addr_q) + BYTES_A;
          state_d   = RD1;
        end else begin
          state_d = RESP;
        end
      end
      RD1:   if (mem_rd_ready) state_d = WAIT1;
      WAIT1: if (mem_rsp_valid) begin
        beat1_d = mem_rsp_data;
        state_d = RESP;
      end
      RESP:  if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop update from pre-edge values.
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rd_addr_q <= '0;
      size_q    <= '0;
      signed_q  <= 1'b0;
      err_q     <= 1'b0;
      beat0_q   <= '0;
      beat1_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rd_addr_q <= rd_addr_d;
      size_q    <= size_d;
      signed_q  <= signed_d;
      err_q     <= err_d;
      beat0_q   <= beat0_d;
      beat1_q   <= beat1_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign mem_rd_valid = (state_q == RD0) || (state_q == RD1);
  assign mem_rd_addr  = rd_addr_q;
  assign resp_valid   = (state_q == RESP);
  assign resp_err     = resp_valid & err_q;
  // Result is decoded purely from flops, so it stays stable for the whole RESP hold.
  assign resp_data    = (resp_valid && !err_q)
                        ? align({beat1_q, beat0_q}, addr_q[OFS_W-1:0], size_q, signed_q)
                        : '0;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit (DATA_W=32): one instance with splitting enabled,
// one with it disabled; a cycle-level bus responder lives inside the load task.
module tb_load_align_unit;

  logic        clk;
  logic        rst;
  logic        req_valid, req_valid_ns;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        mem_rd_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        resp_ready;

  logic        req_ready, mem_rd_valid, resp_valid, resp_err;
  logic [31:0] mem_rd_addr, resp_data;
  logic        req_ready_ns, mem_rd_valid_ns, resp_valid_ns, resp_err_ns;
  logic [31:0] mem_rd_addr_ns, resp_data_ns;

  int n_checks = 0;
  int n_errors = 0;

  load_align_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_signed(req_signed),
    .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_err(resp_err)
  );

  load_align_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(1'b0)) u_dut_ns (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_ns), .req_ready(req_ready_ns), .req_addr(req_addr),
    .req_size(req_size), .req_signed(req_signed),
    .mem_rd_valid(mem_rd_valid_ns), .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr_ns),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .resp_valid(resp_valid_ns), .resp_ready(resp_ready), .resp_data(resp_data_ns),
    .resp_err(resp_err_ns)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Issues one load and plays the memory: first read stalls rd_stall cycles, each read
  // returns data on the cycle after acceptance; result is held rsp_stall extra cycles.
  task automatic run_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic sgn, input logic [31:0] b0, input logic [31:0] b1,
                          input int exp_reads, input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] exp_data, input logic exp_err, input int exp_lat,
                          input int rd_stall, input int rsp_stall);
    int   nreads = 0;
    int   lat    = 0;
    int   stall  = rd_stall;
    logic pend   = 1'b0;
    @(negedge clk);
    check({tag, ".req_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_addr = addr; req_size = size; req_signed = sgn;
    for (int cyc = 1; cyc <= 40 && lat == 0; cyc++) begin
      @(negedge clk);
      req_valid     = 1'b0;
      mem_rsp_valid = pend;
      if (pend) mem_rsp_data = (nreads == 1) ? b0 : b1;
      pend          = 1'b0;
      mem_rd_ready  = 1'b0;
      if (resp_valid) begin
        lat = cyc;
      end else if (mem_rd_valid) begin
        check({tag, ".rd_addr"}, 64'(mem_rd_addr), 64'((nreads == 0) ? a0 : a1));
        if (stall > 0) stall--;
        else begin
          mem_rd_ready = 1'b1;
          nreads++;
          pend = 1'b1;
        end
      end
    end
    mem_rsp_valid = 1'b0;
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".reads"},   64'(nreads), 64'(exp_reads));
    check({tag, ".data"},    64'(resp_data), 64'(exp_data));
    check({tag, ".err"},     64'(resp_err), 64'(exp_err));
    for (int i = 0; i < rsp_stall; i++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, 64'(resp_valid), 64'd1);
      check({tag, ".hold_data"},  64'(resp_data), 64'(exp_data));
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, ".back_idle"}, 64'({resp_valid, mem_rd_valid, req_ready}), 64'b001);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req_ready"},    64'(req_ready), 64'd1);
    check({tag, ".mem_rd_valid"}, 64'(mem_rd_valid), 64'd0);
    check({tag, ".mem_rd_addr"},  64'(mem_rd_addr), 64'd0);
    check({tag, ".resp_valid"},   64'(resp_valid), 64'd0);
    check({tag, ".resp_data"},    64'(resp_data), 64'd0);
    check({tag, ".resp_err"},     64'(resp_err), 64'd0);
  endtask

  initial begin
    int ns_reads;
    rst = 1'b1; req_valid = 1'b0; req_valid_ns = 1'b0; req_addr = '0; req_size = '0;
    req_signed = 1'b0; mem_rd_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    //        tag          addr          sz sg  beat0         beat1         rd a0            a1            data          er lat rs ps
    run_load("word_al",    32'h100,      2, 0,  32'hDEADBEEF, 32'h0,        1, 32'h100,      32'h0,        32'hDEADBEEF, 0, 3, 0, 0);
    run_load("byte3_s",    32'h103,      0, 1,  32'h80123456, 32'h0,        1, 32'h100,      32'h0,        32'hFFFFFF80, 0, 3, 0, 0);
    run_load("byte3_u",    32'h103,      0, 0,  32'h80123456, 32'h0,        1, 32'h100,      32'h0,        32'h00000080, 0, 3, 0, 0);
    run_load("half_x_s",   32'h103,      1, 1,  32'hAB000000, 32'h000000CD, 2, 32'h100,      32'h104,      32'hFFFFCDAB, 0, 5, 0, 0);
    run_load("half_mis_u", 32'h101,      1, 0,  32'h00BEEF00, 32'h0,        1, 32'h100,      32'h0,        32'h0000BEEF, 0, 3, 0, 0);
    run_load("half2_s",    32'h102,      1, 1,  32'h80010000, 32'h0,        1, 32'h100,      32'h0,        32'hFFFF8001, 0, 3, 0, 0);
    run_load("wrap_bp",    32'hFFFFFFFE, 2, 0,  32'h11223344, 32'h55667788, 2, 32'hFFFFFFFC, 32'h00000000, 32'h77881122, 0, 8, 3, 2);
    run_load("dword_32",   32'h100,      3, 0,  32'h0,        32'h0,        0, 32'h0,        32'h0,        32'h0,        1, 1, 0, 0);

    // Misaligned word on the non-splitting instance: error response, no bus traffic.
    @(negedge clk);
    req_valid_ns = 1'b1; req_addr = 32'h102; req_size = 2'd2; req_signed = 1'b0;
    @(negedge clk);
    req_valid_ns = 1'b0;
    ns_reads = int'(mem_rd_valid_ns);
    check("ns.resp_valid", 64'(resp_valid_ns), 64'd1);
    check("ns.resp_err",   64'(resp_err_ns), 64'd1);
    check("ns.resp_data",  64'(resp_data_ns), 64'd0);
    resp_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      ns_reads += int'(mem_rd_valid_ns);
    end
    resp_ready = 1'b0;
    check("ns.no_reads",   64'(ns_reads), 64'd0);
    check("ns.idle",       64'({resp_valid_ns, req_ready_ns}), 64'b01);

    // Reset while WAIT1 is pending, then a stray response for the killed read.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h103; req_size = 2'd1; req_signed = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; mem_rd_ready = 1'b1;
    @(negedge clk);
    mem_rd_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hAB000000;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    check("rst_mid.rd1_addr",  64'({mem_rd_valid, mem_rd_addr}), {31'd0, 1'b1, 32'h104});
    mem_rd_ready = 1'b1;
    @(negedge clk);
    mem_rd_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h12345678;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    check("rst_mid.stray", 64'({resp_valid, resp_data, mem_rd_valid}), 64'd0);
    run_load("after_rst",  32'h100,      2, 0,  32'hCAFEF00D, 32'h0,        1, 32'h100,      32'h0,        32'hCAFEF00D, 0, 3, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
